// File: rtl/gauss_pkg.sv
// Shared types for the Gaussian filter output path: pixel/column types and the write-back state encoding.
package gauss_pkg;

    localparam int BAND_H = 7;

    typedef logic [7:0] pixel_t;
    typedef pixel_t column_t [0:6];

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        FLUSH
    } wb_state_t;

endpackage

// File: rtl/column_pingpong.sv
// Two-slot column buffer: write lands the cycle after wr_en_i, read side presents slot[rd_ptr] combinationally.
// Caller must not write while full_o or release while empty_o; write and release in one cycle keep the count.
module column_pingpong
    import gauss_pkg::*;
(
    input  logic    clk,
    input  logic    rst_i,
    input  logic    wr_en_i,
    input  column_t wr_col_i,
    input  logic    rd_done_i,
    output column_t rd_col_o,
    output logic    full_o,
    output logic    empty_o
);

    column_t    slot_q [0:1];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en_i) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (rd_done_i) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({wr_en_i, rd_done_i})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            for (int s = 0; s < 2; s++) begin
                for (int p = 0; p < BAND_H; p++) begin
                    slot_q[s][p] <= '0;
                end
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (wr_en_i) begin
                slot_q[wr_ptr_q] <= wr_col_i;
            end
        end
    end

    assign rd_col_o = slot_q[rd_ptr_q];
    assign full_o   = (count_q == 2'd2);
    assign empty_o  = (count_q == 2'd0);

endmodule

// File: rtl/gauss_writeback.sv
// Serialises buffered 7-pixel columns into byte writes at raster addresses; first write the cycle after accept.
// sram_ready low holds address/data and stops draining; in_ready drops once both column slots are occupied.
module gauss_writeback
    import gauss_pkg::*;
#(
    parameter int OUT_W     = 250,
    parameter int NUM_BANDS = 36,
    parameter int ADDR_W    = 18
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              gauss_valid,
    input  column_t           gauss_in,
    output logic              in_ready,
    output logic              sram_wr_en,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [7:0]        sram_wdata,
    input  logic              sram_ready,
    output logic              busy,
    output logic              frame_done
);

    localparam int COL_W  = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int BAND_W = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(OUT_W - 1);
    localparam logic [BAND_W-1:0] BAND_LAST = BAND_W'(NUM_BANDS - 1);
    localparam logic [2:0]        K_LAST    = 3'(BAND_H - 1);

    wb_state_t         state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d, col_in_q, col_in_d;
    logic [BAND_W-1:0] band_q, band_d, band_in_q, band_in_d;
    logic [2:0]        k_q, k_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] col_base_q, col_base_d;
    logic [ADDR_W-1:0] next_col_addr;
    logic              frame_done_q, frame_done_d;

    column_t rd_col;
    logic    buf_full, buf_empty;
    logic    accept, wr_hs, col_done, last_in, last_wr;

    assign in_ready   = (state_q == ACTIVE) && !buf_full;
    assign accept     = gauss_valid && in_ready;
    assign sram_wr_en = (state_q != IDLE) && !buf_empty;
    assign wr_hs      = sram_wr_en && sram_ready;
    assign col_done   = wr_hs && (k_q == K_LAST);
    assign last_in    = (col_in_q == COL_LAST) && (band_in_q == BAND_LAST);
    assign last_wr    = (col_q == COL_LAST) && (band_q == BAND_LAST);

    // After the bottom row of the last column in a band, the next band's first byte is just one address on.
    assign next_col_addr = (col_q == COL_LAST) ? addr_q + 1'b1 : col_base_q + 1'b1;

    column_pingpong u_buf (
        .clk       (clk),
        .rst_i     (n_rst),
        .wr_en_i   (accept),
        .wr_col_i  (gauss_in),
        .rd_done_i (col_done),
        .rd_col_o  (rd_col),
        .full_o    (buf_full),
        .empty_o   (buf_empty)
    );

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        band_d       = band_q;
        col_in_d     = col_in_q;
        band_in_d    = band_in_q;
        k_d          = k_q;
        addr_d       = addr_q;
        col_base_d   = col_base_q;
        frame_done_d = 1'b0;

        if (wr_hs) begin
            if (k_q == K_LAST) begin
                k_d        = 3'd0;
                addr_d     = next_col_addr;
                col_base_d = next_col_addr;
                if (col_q == COL_LAST) begin
                    col_d  = '0;
                    band_d = (band_q == BAND_LAST) ? '0 : band_q + 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end else begin
                k_d    = k_q + 3'd1;
                addr_d = addr_q + ADDR_W'(OUT_W);
            end
        end

        if (accept) begin
            if (col_in_q == COL_LAST) begin
                col_in_d  = '0;
                band_in_d = (band_in_q == BAND_LAST) ? '0 : band_in_q + 1'b1;
            end else begin
                col_in_d = col_in_q + 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = ACTIVE;
                    col_d      = '0;
                    band_d     = '0;
                    col_in_d   = '0;
                    band_in_d  = '0;
                    k_d        = 3'd0;
                    addr_d     = base_addr;
                    col_base_d = base_addr;
                end
            end
            ACTIVE: begin
                if (accept && last_in) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (col_done && last_wr) begin
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (n_rst) begin
            state_q      <= IDLE;
            col_q        <= '0;
            band_q       <= '0;
            col_in_q     <= '0;
            band_in_q    <= '0;
            k_q          <= 3'd0;
            addr_q       <= '0;
            col_base_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            band_q       <= band_d;
            col_in_q     <= col_in_d;
            band_in_q    <= band_in_d;
            k_q          <= k_d;
            addr_q       <= addr_d;
            col_base_q   <= col_base_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign sram_addr  = addr_q;
    assign sram_wdata = rd_col[k_q];
    assign busy       = (state_q != IDLE);
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_gauss_writeback.sv
// Scoreboarded bench for gauss_writeback on a 4x2-column frame: ready patterns, hold, overlap, reset and restart.
module tb_gauss_writeback;
    import gauss_pkg::*;

    localparam int OUT_W     = 4;
    localparam int NUM_BANDS = 2;
    localparam int ADDR_W    = 18;

    logic              clk = 1'b0;
    logic              n_rst;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              gauss_valid;
    column_t           gauss_in;
    logic              in_ready;
    logic              sram_wr_en;
    logic [ADDR_W-1:0] sram_addr;
    logic [7:0]        sram_wdata;
    logic              sram_ready;
    logic              busy;
    logic              frame_done;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;

    int checks     = 0;
    int errors     = 0;
    int n_writes   = 0;
    int n_done     = 0;
    int ready_mode = 0;   // 0: tied high, 1: random, 2: held low

    logic [ADDR_W-1:0] m_base;
    int                m_idx;
    int                m_off;

    always #5 clk = ~clk;

    gauss_writeback #(
        .OUT_W     (OUT_W),
        .NUM_BANDS (NUM_BANDS),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .start       (start),
        .base_addr   (base_addr),
        .gauss_valid (gauss_valid),
        .gauss_in    (gauss_in),
        .in_ready    (in_ready),
        .sram_wr_en  (sram_wr_en),
        .sram_addr   (sram_addr),
        .sram_wdata  (sram_wdata),
        .sram_ready  (sram_ready),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] req_v);
        checks++;
        if (act_v !== req_v) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act_v, req_v);
        end
    endtask

    initial begin
        sram_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       sram_ready = 1'b1;
                1:       sram_ready = 1'($urandom_range(0, 1));
                default: sram_ready = 1'b0;
            endcase
        end
    end

    // Monitor: a write retires on the edge following a negedge where wr_en && ready.
    initial begin
        forever begin
            @(negedge clk);
            if (!n_rst) begin
                if (frame_done) n_done++;
                if (sram_wr_en && sram_ready) begin
                    n_writes++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write addr=0x%0h data=0x%0h required=none", sram_addr, sram_wdata);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("wr_addr", 32'(sram_addr), 32'(mon_e.addr));
                        check("wr_data", 32'(sram_wdata), 32'(mon_e.data));
                    end
                end
            end
        end
    end

    task automatic do_start(input logic [ADDR_W-1:0] b);
        base_addr = b;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        base_addr = '0;
    endtask

    task automatic new_frame(input logic [ADDR_W-1:0] b, input int off);
        m_base   = b;
        m_idx    = 0;
        m_off    = off;
        n_writes = 0;
        n_done   = 0;
        do_start(b);
    endtask

    task automatic send_col();
        int col;
        int band;
        bit got;
        col  = m_idx % OUT_W;
        band = m_idx / OUT_W;
        for (int i = 0; i < BAND_H; i++) gauss_in[i] = 8'((16 * m_idx + i + m_off) & 255);
        gauss_valid = 1'b1;
        got = 1'b0;
        for (int cyc = 0; cyc < 300 && !got; cyc++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                for (int k = 0; k < BAND_H; k++)
                    exp_q.push_back('{addr: ADDR_W'(32'(m_base) + band * BAND_H * OUT_W + k * OUT_W + col),
                                      data: gauss_in[k]});
            end
        end
        @(posedge clk);
        #1;
        gauss_valid = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout column=%0d accepted=0 required=1", m_idx);
        end
        m_idx++;
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 1000 && !seen; c++) begin
            @(negedge clk);
            if (frame_done) seen = 1'b1;
        end
        check({tag, "_frame_done"}, 32'(seen), 32'd1);
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        check({tag, "_write_count"}, 32'(n_writes), 32'd56);
        check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(frame_done), 32'd0);
        check({tag, "_done_count"}, 32'(n_done), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_wr_en"}, 32'(sram_wr_en), 32'd0);
        check({tag, "_addr"}, 32'(sram_addr), 32'd0);
        check({tag, "_wdata"}, 32'(sram_wdata), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    endtask

    initial begin
        bit stable;
        bit found;
        n_rst       = 1'b1;
        start       = 1'b0;
        base_addr   = '0;
        gauss_valid = 1'b0;
        for (int i = 0; i < BAND_H; i++) gauss_in[i] = 8'h00;
        m_base = '0;
        m_idx  = 0;
        m_off  = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk);
        #1;
        n_rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;

        // Basic frame, ready tied high
        ready_mode = 0;
        new_frame(18'h01000, 0);
        @(negedge clk);
        check("start_busy", 32'(busy), 32'd1);
        check("start_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        repeat (8) send_col();
        wait_done("basic");

        // Backpressure, full buffer, start while busy, accept blocked at the freeing handshake
        ready_mode = 2;
        @(posedge clk);
        #1;
        new_frame(18'h01000, 8'h80);
        send_col();
        send_col();
        @(negedge clk);
        check("bp_in_ready_full", 32'(in_ready), 32'd0);
        check("bp_wr_en", 32'(sram_wr_en), 32'd1);
        check("bp_first_addr", 32'(sram_addr), 32'h1000);
        check("bp_first_data", 32'(sram_wdata), 32'h80);
        @(posedge clk);
        #1;
        fork
            send_col();
            begin
                stable = 1'b1;
                repeat (10) begin
                    @(negedge clk);
                    if (sram_addr !== 18'h01000 || sram_wdata !== 8'h80 || sram_wr_en !== 1'b1 || in_ready !== 1'b0)
                        stable = 1'b0;
                end
                @(posedge clk);
                #1;
                base_addr = 18'h03000;
                start     = 1'b1;
                @(posedge clk);
                #1;
                start     = 1'b0;
                base_addr = '0;
                repeat (8) begin
                    @(negedge clk);
                    if (sram_addr !== 18'h01000 || sram_wdata !== 8'h80 || sram_wr_en !== 1'b1 || in_ready !== 1'b0)
                        stable = 1'b0;
                end
                check("bp_hold_stable", 32'(stable), 32'd1);
                check("bp_busy_after_restart", 32'(busy), 32'd1);
                ready_mode = 0;
                found = 1'b0;
                for (int c = 0; c < 50 && !found; c++) begin
                    @(negedge clk);
                    if (sram_wr_en && sram_ready && sram_addr == 18'h01018) found = 1'b1;
                end
                check("ovl_k6_seen", 32'(found), 32'd1);
                check("ovl_in_ready_at_free", 32'(in_ready), 32'd0);
                @(negedge clk);
                check("ovl_in_ready_after_free", 32'(in_ready), 32'd1);
            end
        join
        repeat (5) send_col();
        wait_done("bp");

        // Random ready, base near the top of the address space so addresses wrap
        ready_mode = 1;
        new_frame(18'h3FFF0, 8'h40);
        repeat (8) send_col();
        wait_done("rand");

        // Reset with about 1.5 columns buffered, then a fresh frame
        ready_mode = 0;
        new_frame(18'h01000, 8'h20);
        send_col();
        send_col();
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        gauss_valid = 1'b0;
        @(negedge clk);
        check_outputs_zero("midrst");
        @(posedge clk);
        #1;
        n_rst = 1'b0;
        new_frame(18'h02000, 8'h30);
        send_col();
        @(negedge clk);
        check("rst_first_wr_en", 32'(sram_wr_en), 32'd1);
        check("rst_first_addr", 32'(sram_addr), 32'h2000);
        check("rst_first_data", 32'(sram_wdata), 32'h30);
        @(posedge clk);
        #1;
        repeat (7) send_col();
        wait_done("rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/gauss_writeback.md
# gauss_writeback

Write-back stage at the output of the Gaussian filter. Accepts one 7-pixel filtered column per handshake, buffers up to two columns, and serialises them into single-byte SRAM writes at raster addresses of the output image. It tracks column and band position across a frame and pulses `frame_done` after the last byte of the frame is written.

## Interface
- `OUT_W`, 250: output image width in pixels (columns per band).
- `NUM_BANDS`, 36: number of 7-row bands per frame.
- `ADDR_W`, 18: SRAM byte-address width.
- `clk` in 1: sole clock, rising edge.
- `n_rst` in 1: reset. Synchronous, active-high (1 = reset).
- `start` in 1: one-cycle frame start. Honoured only in IDLE.
- `base_addr` in ADDR_W: output frame base address. Sampled on an accepted `start`.
- `gauss_valid` in 1: `gauss_in` holds a valid column.
- `gauss_in[0:6]` in 7×8: filtered pixels. Index 0 is the top row of the band.
- `in_ready` out 1: the block can accept a column this cycle.
- `sram_wr_en` out 1: write request.
- `sram_addr` out ADDR_W: write address.
- `sram_wdata` out 8: write byte.
- `sram_ready` in 1: SRAM accepts the write this cycle.
- `busy` out 1: state is not IDLE.
- `frame_done` out 1: one-cycle pulse after the last write of the frame.

## Operation
- **States: IDLE → ACTIVE → FLUSH → IDLE.**
  - IDLE:
    - `in_ready=0`.
    - `start` latches `base_addr`, clears the col, band and k counters, and moves to ACTIVE.
  - ACTIVE:
    - `in_ready = (count<2)`.
    - An accept is `gauss_valid && in_ready`. It writes `gauss_in` into slot `wr_ptr`, toggles `wr_ptr` and increments `count`.
  - FLUSH:
    - Entered when the final column (col=OUT_W−1, band=NUM_BANDS−1) is accepted.
    - `in_ready=0`.
    - Returns to IDLE after the final write handshakes, with `frame_done` pulsing that cycle.
- **Drain (ACTIVE and FLUSH):**
  - While `count>0`, `sram_wr_en=1` and `sram_wdata = slot[rd_ptr][k]`.
  - `sram_addr = row_base + k*OUT_W + col`, where `row_base = base + band*7*OUT_W`. Use an incrementally maintained row pointer; no multiplier.
  - Write handshake: `sram_wr_en && sram_ready`. It advances k.
  - At k=6 the handshake frees the slot: `rd_ptr` toggles, `count` decrements, k returns to 0, and col/band advance.
    - col wraps OUT_W−1→0 and increments band.
    - band wraps NUM_BANDS−1→0 at frame end.
- **Outputs while waiting:** `sram_addr` and `sram_wdata` are held stable while `sram_wr_en=1 && !sram_ready`.
- **Simultaneous accept and slot free:** `count` is unchanged, both pointers toggle, and no data is lost.
- **`start` outside IDLE:** ignored.
- **`gauss_valid` while `in_ready=0`:** ignored; the column is not captured.
- **Accept and write counters:** the accept counter (col_in/band_in) is separate from the write counter so FLUSH detection needs no lookahead.
- **Address overflow:** wraps modulo 2^ADDR_W; there is no error flag.

## Timing
- **Reset values:** `in_ready=0`, `sram_wr_en=0`, `sram_addr=0`, `sram_wdata=0`, `busy=0`, `frame_done=0`. All counters, pointers and `count` are 0, and the slots are cleared.
- **Reset mid-frame:** discards buffered columns and returns to IDLE on the next edge. No write is issued in the cycle after reset.
- **`start`:** `busy=1` and `in_ready=1` from the cycle after `start`.
- **Output registering:** SRAM outputs are registered. The first `sram_wr_en` appears the cycle after the first accept.
- **Throughput:** with `sram_ready` tied high, one byte per cycle, so 7 cycles per column. Upstream sustains one column per 7 cycles without stalls.
- **`frame_done`:** asserts in the cycle after the final handshake, together with `busy=0`.

## Structure
- **Package `gauss_pkg`:**
  - `typedef logic [7:0] pixel_t`
  - `typedef pixel_t column_t [0:6]`
  - `localparam BAND_H = 7`
  - state enum `wb_state_t {IDLE, ACTIVE, FLUSH}`
- **Sub-module `column_pingpong`:** the 2-slot column buffer with `wr_ptr`, `rd_ptr`, `count`, full and empty. The FSM and address generation stay in `gauss_writeback`.

## Test plan
- **Basic frame:** OUT_W=4, NUM_BANDS=2, base=0x1000, `sram_ready=1`; feed 8 columns with `gauss_in[i] = 16*col + i`.
  - Column 0 writes bytes 0x00..0x06 to 0x1000, 0x1004, …, 0x1018.
  - Band 1, col 0, writes to 0x101C onwards.
  - 56 writes total, then `frame_done` pulses once and `busy=0`.
- **Backpressure:** hold `sram_ready=0` for 20 cycles after the first write request.
  - `sram_addr` and `sram_wdata` stay stable.
  - `in_ready` drops after the 2nd accept.
  - A third `gauss_valid` is not captured.
- **Simultaneous accept and free:** with count=2, present `gauss_valid` in the cycle of the k=6 handshake.
  - `in_ready` is 0, so the column is not taken.
  - Next cycle `count=1` and `in_ready=1`; accept, and the columns are written in order.
- **Random `sram_ready`:** 50% duty over a full frame. The scoreboard matches all 56 address/data pairs in raster order.
- **Reset mid-frame:** assert `n_rst` with 1.5 columns buffered.
  - Next cycle all outputs are 0 and `busy=0`.
  - A new `start` with base=0x2000 writes its first byte to 0x2000.
- **`start` while busy:** pulse `start` with base=0x3000 mid-frame. Addresses continue from 0x1000 and there is no restart.
